// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - register scoreboard and branch-flush issue sequencer for the decode stage
// Optional feature: SCOREBOARD_WB_BYPASS_EN lets a same-cycle final writeback clear a source hazard.
module id_scoreboard #(
    parameter int ADDRESS_LEN_REG_FILE = 4,
    parameter int SIZE_REG_FILE        = 15,
    parameter int MAX_INFLIGHT         = 3,
    parameter int FLUSH_CYCLES         = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            id_valid,
    input  logic                            id_wb_en,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] id_dest,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] id_src1,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] id_src2,
    input  logic                            id_two_src,
    input  logic                            branch_taken,
    input  logic                            wb_en,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] wb_dest,
    output logic                            hazard,
    output logic                            flush,
    output logic                            issue,
    output logic [SIZE_REG_FILE-1:0]        busy_mask,
    output logic                            underflow_err
);

    localparam int AW   = ADDRESS_LEN_REG_FILE;
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);
    localparam int NREG = 2 ** AW;

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_INFLIGHT);
    localparam logic [AW:0]   NUM_TRK    = (AW + 1)'(SIZE_REG_FILE);
    localparam logic [3:0]    FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    // Full index-space view; untracked indices (the PC) read as an idle counter.
    logic [CW-1:0]   cnt_view [NREG];
    logic [NREG-1:0] busy_vec;
    logic [3:0]      flush_cnt;

    logic src1_busy;
    logic src2_busy;
    logic sat_stall;
    logic inc_en;
    logic dec_en;

    always_comb begin
        src1_busy = busy_vec[id_src1];
        src2_busy = busy_vec[id_src2];
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Register file writes before it reads, so the last pending write landing now is visible.
        if (wb_en && (wb_dest == id_src1) && (cnt_view[id_src1] == ONE)) begin
            src1_busy = 1'b0;
        end
        if (wb_en && (wb_dest == id_src2) && (cnt_view[id_src2] == ONE)) begin
            src2_busy = 1'b0;
        end
`endif
    end

    assign sat_stall = id_wb_en & (cnt_view[id_dest] == MAX_CNT);
    assign hazard    = id_valid & (src1_busy | (id_two_src & src2_busy) | sat_stall);
    assign flush     = branch_taken | (flush_cnt != 4'd0);
    assign issue     = id_valid & ~hazard & ~flush;

    assign inc_en    = issue & id_wb_en & ({1'b0, id_dest} < NUM_TRK);
    assign dec_en    = wb_en & ({1'b0, wb_dest} < NUM_TRK);
    assign busy_mask = busy_vec[SIZE_REG_FILE-1:0];

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (g < SIZE_REG_FILE) begin : g_trk
            localparam logic [AW-1:0] IDX = AW'(g);
            logic [CW-1:0] cnt;
            logic          inc_hit;
            logic          dec_hit;

            assign inc_hit = inc_en & (id_dest == IDX);
            assign dec_hit = dec_en & (wb_dest == IDX);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt <= '0;
                end else if (inc_hit && !dec_hit) begin
                    cnt <= cnt + ONE;
                end else if (dec_hit && !inc_hit && (cnt != '0)) begin
                    cnt <= cnt - ONE;
                end
            end

            assign cnt_view[g] = cnt;
        end else begin : g_untrk
            assign cnt_view[g] = '0;
        end
        assign busy_vec[g] = (cnt_view[g] != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_err <= 1'b0;
        end else if (dec_en && (cnt_view[wb_dest] == '0)) begin
            underflow_err <= 1'b1;
        end
    end

    // A branch during an active flush restarts the window rather than extending it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= 4'd0;
        end else if (branch_taken) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed and random check of id_scoreboard against a reference model
module tb_id_scoreboard;

    localparam int MAXI = 3;
    localparam int FLC  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_wb_en, id_two_src, branch_taken, wb_en;
    logic [3:0] id_dest, id_src1, id_src2, wb_dest;
    logic       hazard, flush, issue, underflow_err;
    logic [14:0] busy_mask;

    int checks = 0;
    int errors = 0;

    int m_cnt [15];
    int m_fc;
    bit m_uf;
    bit obs_hazard, obs_issue, obs_flush;

    id_scoreboard #(
        .ADDRESS_LEN_REG_FILE(4),
        .SIZE_REG_FILE(15),
        .MAX_INFLIGHT(MAXI),
        .FLUSH_CYCLES(FLC)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .branch_taken(branch_taken), .wb_en(wb_en), .wb_dest(wb_dest),
        .hazard(hazard), .flush(flush), .issue(issue),
        .busy_mask(busy_mask), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        if (r == 15 || m_cnt[r] == 0) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (m_cnt[r] == 1 && wb_en && int'(wb_dest) == r) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [14:0] m_mask();
        logic [14:0] m = '0;
        for (int i = 0; i < 15; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_cnt[i] = 0;
        m_fc = 0;
        m_uf = 1'b0;
    endtask

    task automatic step(input bit v, input bit we, input int d, input int s1, input int s2,
                        input bit two, input bit br, input bit wbe, input int wbd);
        bit eh, ef, ei, inc, dec;
        @(negedge clk);
        id_valid = v; id_wb_en = we; id_dest = 4'(d); id_src1 = 4'(s1); id_src2 = 4'(s2);
        id_two_src = two; branch_taken = br; wb_en = wbe; wb_dest = 4'(wbd);
        #1;
        eh = v && (m_busy(s1) || (two && m_busy(s2)) || (we && d != 15 && m_cnt[d] == MAXI));
        ef = br || (m_fc != 0);
        ei = v && !eh && !ef;
        check("hazard", hazard, eh);
        check("flush", flush, ef);
        check("issue", issue, ei);
        check("busy_mask", busy_mask, m_mask());
        check("underflow_err", underflow_err, m_uf);
        obs_hazard = hazard; obs_issue = issue; obs_flush = flush;
        @(posedge clk);
        inc = ei && we && d != 15;
        dec = wbe && wbd != 15;
        if (dec && m_cnt[wbd] == 0) m_uf = 1'b1;
        if (!(inc && dec && d == wbd)) begin
            if (inc) m_cnt[d]++;
            if (dec && m_cnt[wbd] > 0) m_cnt[wbd]--;
        end
        if (br) m_fc = FLC - 1;
        else if (m_fc > 0) m_fc--;
    endtask

    task automatic async_reset_check(input int src);
        @(negedge clk);
        id_valid = 1'b1; id_wb_en = 1'b0; id_src1 = 4'(src); id_two_src = 1'b0;
        branch_taken = 1'b0; wb_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_busy_mask", busy_mask, 15'd0);
        check("rst_hazard", hazard, 1'b0);
        check("rst_underflow", underflow_err, 1'b0);
        check("rst_flush", flush, 1'b0);
        model_reset();
        @(negedge clk);
        id_valid = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int pend [$];
        int d, s1, s2, wbd;
        bit wbe;
        model_reset();
        rst = 1'b0;
        id_valid = 1'b1; id_wb_en = 1'b0; id_dest = 4'd0; id_src1 = 4'd3; id_src2 = 4'd0;
        id_two_src = 1'b0; branch_taken = 1'b0; wb_en = 1'b0; wb_dest = 4'd0;
        #1;
        check("reset_hazard", hazard, 1'b0);
        check("reset_flush", flush, 1'b0);
        check("reset_issue", issue, 1'b1);
        check("reset_busy_mask", busy_mask, 15'd0);
        check("reset_underflow", underflow_err, 1'b0);
        id_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // RAW on R3
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 0, 0, 0);
        check("raw_stall", obs_hazard, 1'b1);
        step(1, 0, 0, 3, 0, 0, 0, 1, 3);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw_bypass_issue", obs_issue, 1'b1);
`else
        check("raw_wb_cycle_stall", obs_hazard, 1'b1);
`endif
        step(1, 0, 0, 3, 0, 0, 0, 0, 0);
        check("raw_issue_after_wb", obs_issue, 1'b1);

        // Store second source on R5
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 0, 0);
        check("store_src2_hazard", obs_hazard, 1'b1);
        step(1, 0, 0, 0, 5, 0, 0, 0, 0);
        check("store_one_src_free", obs_hazard, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5);

        // Saturation on R7
        for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        check("sat_hazard", obs_hazard, 1'b1);
        step(1, 1, 7, 0, 0, 0, 0, 1, 7);
        check("sat_wb_cycle", obs_hazard, 1'b1);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        check("sat_issue_after_wb", obs_issue, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 7);

        // Branch flush, then back-to-back branches
        step(1, 1, 4, 0, 0, 0, 1, 0, 0);
        check("flush_n", obs_flush, 1'b1);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        check("flush_n1_issue", obs_issue, 1'b0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        check("flush_done_issue", obs_issue, 1'b1);
        step(1, 0, 0, 0, 0, 0, 1, 1, 4);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_restart_n2", obs_flush, 1'b1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_restart_end", obs_flush, 1'b0);

        // Same-cycle issue and writeback on R2, then underflow on R9
        step(1, 1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 1, 2);
        #1 check("simul_r2_busy", busy_mask[2], 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9);
        #1 check("underflow_set", underflow_err, 1'b1);
        check("underflow_r9_idle", busy_mask[9], 1'b0);

        // PC exclusion and async reset mid-stall
        step(1, 1, 15, 15, 15, 1, 0, 0, 0);
        check("pc_no_stall", obs_hazard, 1'b0);
        #1 check("pc_not_counted", busy_mask, 15'd0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 0, 0, 0);
        async_reset_check(3);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pend.delete();
            for (int i = 0; i < 15; i++) if (m_cnt[i] != 0) pend.push_back(i);
            d  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 7));
            s1 = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 7));
            s2 = int'($urandom_range(0, 15));
            wbe = 1'b0;
            wbd = 0;
            if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
                wbe = 1'b1;
                wbd = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 30) == 0) begin
                wbe = 1'b1;
                wbd = int'($urandom_range(0, 15));
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), d, s1, s2,
                 $urandom_range(0, 1), $urandom_range(0, 19) == 0, wbe, wbd);
            if ($urandom_range(0, 699) == 0) async_reset_check(s1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
